// File: rtl/mesh_pkg.sv
// Shared types and constants for the 2D-mesh switch allocator.
// MESH_WORMHOLE_LOCK_EN adds the per-output lock state type.
package mesh_pkg;

  localparam int N_PORTS = 5;

  localparam int PORT_C = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  typedef logic [0:N_PORTS-1] port_vec_t;

`ifdef MESH_WORMHOLE_LOCK_EN
  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;
`endif

endpackage

// File: rtl/mesh_rr_arbiter.sv
// Per-output round-robin arbiter; grant is combinational, pointer updates at the edge.
// With MESH_WORMHOLE_LOCK_EN the output holds to one input until its tail flit passes.
module mesh_rr_arbiter
  import mesh_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  port_vec_t req,
`ifdef MESH_WORMHOLE_LOCK_EN
  input  port_vec_t tail,
`endif
  input  logic      ready,
  output port_vec_t grant
);

  // state  | meaning
  // IDLE   | round-robin among all requesters
  // LOCKED | only the owner may use the output until its tail flit

  logic [2:0] ptr;
  logic [2:0] win;
  logic       found;
  port_vec_t  cand;

`ifdef MESH_WORMHOLE_LOCK_EN
  lock_state_e state;
  logic [2:0]  owner;

  always_comb begin
    cand = req;
    if (state == LOCKED) begin
      cand        = '0;
      cand[owner] = req[owner];
    end
  end
`else
  assign cand = req;
`endif

  // First candidate after ptr wins, wrapping 4 -> 0.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = ptr;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(ptr) + k) % N_PORTS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (reset_n && ready && found) grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= 3'(N_PORTS - 1);
`ifdef MESH_WORMHOLE_LOCK_EN
      state <= IDLE;
      owner <= '0;
`endif
    end else if (|grant) begin
      ptr <= win;
`ifdef MESH_WORMHOLE_LOCK_EN
      case (state)
        IDLE: begin
          if (!tail[win]) begin
            state <= LOCKED;
            owner <= win;
          end
        end
        LOCKED: begin
          if (tail[win]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: rtl/mesh_switch_allocator.sv
// Router switch allocator: one round-robin arbiter per output, grants in the request cycle.
// Define MESH_WORMHOLE_LOCK_EN for packet-level (wormhole) output locking.
module mesh_switch_allocator
  import mesh_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [0:N_PORTS-1][0:N_PORTS-1]   i_output_req,
  input  logic [0:N_PORTS-1]                i_tail,
  input  logic [0:N_PORTS-1]                i_output_ready,
  output logic [0:N_PORTS-1]                o_input_grant,
  output logic [0:N_PORTS-1][0:N_PORTS-1]   o_output_sel,
  output logic [0:N_PORTS-1]                o_output_val
);

  logic [0:N_PORTS-1][0:N_PORTS-1] req_t;
  logic [0:N_PORTS-1][0:N_PORTS-1] grant_o;
  logic [0:N_PORTS-1]              legal;

`ifndef MESH_WORMHOLE_LOCK_EN
  logic unused_tail;
  assign unused_tail = ^i_tail;
`endif

  // Multi-hot requests are dropped here so they never reach any arbiter.
  always_comb begin
    req_t = '0;
    legal = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      legal[i] = $onehot(i_output_req[i]);
      for (int o = 0; o < N_PORTS; o++) begin
        req_t[o][i] = legal[i] & i_output_req[i][o];
      end
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    mesh_rr_arbiter u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_t[o]),
`ifdef MESH_WORMHOLE_LOCK_EN
      .tail    (i_tail),
`endif
      .ready   (i_output_ready[o]),
      .grant   (grant_o[o])
    );
  end

  assign o_output_sel = grant_o;

  always_comb begin
    o_input_grant = '0;
    o_output_val  = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      o_output_val[o] = |grant_o[o];
      for (int i = 0; i < N_PORTS; i++) begin
        o_input_grant[i] = o_input_grant[i] | grant_o[o][i];
      end
    end
  end

endmodule

// File: tb/tb_mesh_switch_allocator.sv
// Directed and random checks of mesh_switch_allocator against a distance-based reference model.
// Lock scenarios run only when MESH_WORMHOLE_LOCK_EN is defined.
module tb_mesh_switch_allocator;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [0:4][0:4]      req;
  logic [0:4]           tail;
  logic [0:4]           rdy;
  logic [0:4]           o_input_grant;
  logic [0:4][0:4]      o_output_sel;
  logic [0:4]           o_output_val;

  int total = 0;
  int bad   = 0;

  // reference model state
  int  m_ptr   [5];
  bit  m_locked[5];
  int  m_owner [5];
  int  m_win   [5];
  logic [0:4]      exp_grant;
  logic [0:4][0:4] exp_sel;
  logic [0:4]      exp_val;
  logic [0:4]      obs_grant;
  logic [0:4][0:4] obs_sel;
  logic [0:4]      obs_val;

  always #5 clk = ~clk;

  mesh_switch_allocator dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_output_req   (req),
    .i_tail         (tail),
    .i_output_ready (rdy),
    .o_input_grant  (o_input_grant),
    .o_output_sel   (o_output_sel),
    .o_output_val   (o_output_val)
  );

  // Winner is the eligible requester closest after ptr in circular order.
  function automatic void predict();
    exp_grant = '0;
    exp_sel   = '0;
    exp_val   = '0;
    for (int o = 0; o < 5; o++) begin
      int best;
      int bestd;
      best  = -1;
      bestd = 99;
      m_win[o] = -1;
      if (reset_n && rdy[o]) begin
        for (int i = 0; i < 5; i++) begin
          int d;
          if ($countones(req[i]) == 1 && req[i][o] && !(m_locked[o] && i != m_owner[o])) begin
            d = (i - m_ptr[o] + 4) % 5;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
      end
      if (best >= 0) begin
        m_win[o]           = best;
        exp_sel[o][best]   = 1'b1;
        exp_val[o]         = 1'b1;
        exp_grant[best]    = 1'b1;
      end
    end
  endfunction

  function automatic void update();
    for (int o = 0; o < 5; o++) begin
      if (!reset_n) begin
        m_ptr[o]    = 4;
        m_locked[o] = 1'b0;
        m_owner[o]  = 0;
      end else if (m_win[o] >= 0) begin
        m_ptr[o] = m_win[o];
`ifdef MESH_WORMHOLE_LOCK_EN
        if (!m_locked[o] && !tail[m_win[o]]) begin
          m_locked[o] = 1'b1;
          m_owner[o]  = m_win[o];
        end else if (m_locked[o] && tail[m_win[o]]) begin
          m_locked[o] = 1'b0;
        end
`endif
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Inputs are already driven; check at negedge, advance model at posedge.
  task automatic cycle(input string tag);
    @(negedge clk);
    predict();
    obs_grant = o_input_grant;
    obs_sel   = o_output_sel;
    obs_val   = o_output_val;
    chk({tag, "_grant"}, 25'(obs_grant), 25'(exp_grant));
    chk({tag, "_sel"},   25'(obs_sel),   25'(exp_sel));
    chk({tag, "_val"},   25'(obs_val),   25'(exp_val));
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle_inputs();
    req  = '0;
    tail = '1;
    rdy  = '1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    logic [0:4] seq_exp;
    int seq [6];
    seq = '{1, 2, 4, 1, 2, 4};
    for (int o = 0; o < 5; o++) begin
      m_ptr[o] = 4; m_locked[o] = 1'b0; m_owner[o] = 0; m_win[o] = -1;
    end

    // reset with requests present: everything forced low
    reset_n = 1'b0;
    idle_inputs();
    req[0] = 5'b00100;
    req[1] = 5'b10000;
    cycle("reset_forced");
    chk("reset_grant_zero", 25'(obs_grant), 25'd0);
    reset_n = 1'b1;

    // two inputs contend for east
    idle_inputs();
    req[0] = 5'b00100;
    req[3] = 5'b00100;
    cycle("east1");
    chk("east1_sel2", 25'(obs_sel[2]), 25'(5'b10000));
    cycle("east2");
    chk("east2_grant", 25'(obs_grant), 25'(5'b00010));

    // three inputs hammer local
    idle_inputs();
    req[1] = 5'b10000;
    req[2] = 5'b10000;
    req[4] = 5'b10000;
    for (int k = 0; k < 6; k++) begin
      cycle("local_rr");
      seq_exp = 5'b10000 >> seq[k];
      chk("local_rr_const", 25'(obs_grant), 25'(seq_exp));
      chk("local_val0", 25'(obs_val[0]), 25'd1);
    end

    // north held off by backpressure
    idle_inputs();
    req[2] = 5'b01000;
    rdy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle("north_wait");
      chk("north_wait_none", 25'(obs_grant), 25'd0);
    end
    rdy[1] = 1'b1;
    cycle("north_go");
    chk("north_go_grant", 25'(obs_grant), 25'(5'b00100));

    // illegal multi-hot request beside a legal one
    idle_inputs();
    req[4] = 5'b01100;
    req[0] = 5'b00010;
    cycle("illegal");
    chk("illegal_grant", 25'(obs_grant), 25'(5'b10000));

    // five distinct outputs in parallel
    idle_inputs();
    req[0] = 5'b01000;
    req[1] = 5'b00100;
    req[2] = 5'b00010;
    req[3] = 5'b00001;
    req[4] = 5'b10000;
    cycle("parallel");
    chk("parallel_grant", 25'(obs_grant), 25'(5'b11111));

`ifdef MESH_WORMHOLE_LOCK_EN
    idle_inputs();
    do_reset();
    req[1] = 5'b00001;
    req[3] = 5'b00001;
    tail   = 5'b00000;
    cycle("lock_head");
    chk("lock_head_g", 25'(obs_grant), 25'(5'b01000));
    cycle("lock_body");
    chk("lock_body_g", 25'(obs_grant), 25'(5'b01000));
    req[1] = 5'b00000;
    cycle("lock_bubble");
    chk("lock_bubble_v", 25'(obs_val[4]), 25'd0);
    req[1] = 5'b00001;
    tail   = 5'b01000;
    cycle("lock_tail");
    chk("lock_tail_g", 25'(obs_grant), 25'(5'b01000));
    req[1] = 5'b00000;
    tail   = 5'b00000;
    cycle("lock_other");
    chk("lock_other_g", 25'(obs_grant), 25'(5'b00010));
    req[1] = 5'b00001;
    req[3] = 5'b00001;
    cycle("lock_head2");
    do_reset();
    req[1] = 5'b00000;
    cycle("lock_after_reset");
    chk("lock_after_reset_g", 25'(obs_grant), 25'(5'b00010));
`endif

    // random traffic
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 5; i++) begin
        int r;
        int a;
        int b;
        r = $urandom_range(0, 9);
        a = $urandom_range(0, 4);
        req[i] = '0;
        if (r >= 3) begin
          req[i][a] = 1'b1;
        end else if (r == 2) begin
          b = (a + 1 + $urandom_range(0, 3)) % 5;
          req[i][a] = 1'b1;
          req[i][b] = 1'b1;
        end
        tail[i] = $urandom_range(0, 1) == 1;
        rdy[i]  = $urandom_range(0, 4) != 0;
      end
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesh_switch_allocator.md
Name: mesh_switch_allocator

Overview:
- Per-router switch allocator for the 2D-mesh router.
- Takes the one-hot [c,n,e,s,w] output requests from the five per-input route calculators (one per input FIFO) and decides, per output port, which input drives the crossbar each cycle.
- Uses round-robin fairness per output and honours downstream readiness.
- Produces input-side grants (FIFO pop) and output-side crossbar selects.

Parameters:
- N_PORTS, 5, number of router ports, index order c=0, n=1, e=2, s=3, w=4. Only 5 is supported for the mesh.

Ports:
- clk  input  1  router clock.
- reset_n  input  1  synchronous, active-low reset.
- i_output_req  input  [0:N_PORTS-1][0:N_PORTS-1]  per input i, one-hot output request from that input's route calculator; all-zero means no request.
- i_tail  input  [0:N_PORTS-1]  flit at head of input i is a packet tail.
- i_output_ready  input  [0:N_PORTS-1]  downstream of output o can accept a flit this cycle.
- o_input_grant  output  [0:N_PORTS-1]  input i's head flit crosses the switch this cycle (FIFO pop).
- o_output_sel  output  [0:N_PORTS-1][0:N_PORTS-1]  per output o, one-hot crossbar select of the driving input.
- o_output_val  output  [0:N_PORTS-1]  output o carries a valid flit this cycle.

Behaviour:
- Grants are combinational from current requests plus registered state, so switch traversal happens in the same cycle as the request. State updates at the clk edge.
- While reset_n=0:
  - all outputs are forced to 0;
  - every ptr[o] is set to 4, so input 0 has highest priority first;
  - all output locks are cleared.
- Request validity: an i_output_req[i] vector with more than one bit set is illegal and is treated as no request. It produces no grant.
- Per output o, candidates are inputs i with i_output_req[i][o]=1.
- Round-robin search order is ptr[o]+1, ptr[o]+2, …, ptr[o]+N_PORTS, mod N_PORTS (wrap 4→0). The first candidate found wins.
- A grant is issued only if i_output_ready[o]=1. If not ready: no grant, no state change, and the requester keeps waiting.
- On a grant to input w at output o:
  - o_output_sel[o] is one-hot on w;
  - o_output_val[o]=1;
  - o_input_grant[w]=1;
  - at the next edge, ptr[o] <= w.
- No input conflicts: a legal request is one-hot, so each input can win at most one output. Outputs are arbitrated independently and in parallel, so up to 5 grants per cycle.
- An input requesting the output of its own index (e.g. local→local) is legal and treated like any other request.
- Any inputs that lose stay requesting, with no starvation. Worst-case wait is N_PORTS-1 grants of that output while it is ready.
- Without MESH_WORMHOLE_LOCK_EN, i_tail is ignored and every flit is arbitrated independently.

Optional Feature:
- Macro: MESH_WORMHOLE_LOCK_EN.
- When defined, each output has a 2-state FSM: IDLE and LOCKED(owner).
  - IDLE: round-robin as above. On a grant to w with i_tail[w]=0, go to LOCKED with owner=w. With i_tail[w]=1 (single-flit packet), stay IDLE.
  - LOCKED: only the owner is a candidate, and other requesters are never granted. On a grant to the owner with i_tail=1, return to IDLE.
  - If the owner drops its request or the output is not ready, stay LOCKED and output nothing (a bubble).
  - ptr[o] updates on every grant, including locked ones.
  - Reset mid-packet returns every output to IDLE.
- When not defined, the FSM and lock registers are absent and the block behaves as flit-level round-robin.

Decomposition:
- Package mesh_pkg:
  - port index constants PORT_C..PORT_W;
  - N_PORTS;
  - typedef port_vec_t (logic [0:N_PORTS-1]);
  - typedef lock_state_e {IDLE, LOCKED}, under the macro.
- Sub-module mesh_rr_arbiter: one instance per output. It contains the request vector, ready, ptr register, rotating priority search and the optional lock FSM, and outputs a one-hot grant.
- The top level transposes requests (input-major to output-major) and ORs the per-output grants into o_input_grant.

Test Plan:
- Reset, then input 0 requests east (00100) and input 3 requests east in the same cycle, with i_output_ready[2]=1 → input 0 granted, o_output_sel[2]=10000. Next cycle, both still requesting → input 3 granted.
- Inputs 1, 2, 4 continuously request local (10000) for 6 cycles → grant sequence 1,2,4,1,2,4 and o_output_val[0]=1 every cycle.
- Input 2 requests north with i_output_ready[1]=0 for 3 cycles, then ready=1 → no grant for 3 cycles, grant on the 4th, ptr[1] becomes 2.
- Illegal request 01100 on input 4 → no grant anywhere; all other ports unaffected.
- MESH_WORMHOLE_LOCK_EN: input 1 sends head/body/tail to west while input 3 also requests west → grants 1,1,1 (including a bubble cycle when input 1 deasserts its request), then 3. Assert reset_n=0 mid-packet → lock cleared, and after reset input 3 can win.
- Parallel: five inputs request five distinct outputs, all ready → five simultaneous grants in one cycle.
